// File: rtl/sc_out_port_display.sv
// Output-port word to DE2 seven-segment display: sequential double-dabble conversion, atomic update.
// Optional leading-zero blanking is enabled by defining OUT_PORT_DISPLAY_LZB_EN.
module sc_out_port_display #(
    parameter int DATA_W = 26,
    parameter int DIGITS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           out_port,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex_seg,
    output logic                  busy,
    output logic                  valid,
    output logic                  ovf,
    output logic [1:0]            dbg_state
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [31:0]           r_last;
    logic                  r_force;
    logic                  r_ovf_path;
    logic [DATA_W-1:0]     r_shift;
    logic [4*DIGITS-1:0]   r_work;
    logic [CNT_W-1:0]      r_cnt;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [7*DIGITS-1:0]   r_hex;
    logic                  r_busy;
    logic                  r_valid;
    logic                  r_ovf;

    logic                  w_hi_nz;
    logic [4*DIGITS-1:0]   w_adj;
    logic [7*DIGITS-1:0]   w_seg;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign w_hi_nz = (out_port >> DATA_W) != 32'd0;

    // Add-3 correction per nibble, no carry between nibbles.
    always_comb begin
        w_adj = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_work[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_work[4*d +: 4] + 4'd3;
            else
                w_adj[4*d +: 4] = r_work[4*d +: 4];
        end
    end

    always_comb begin
`ifdef OUT_PORT_DISPLAY_LZB_EN
        logic v_seen;
        v_seen = 1'b0;
        w_seg  = '1;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            if (r_work[4*d +: 4] != 4'd0 || d == 0)
                v_seen = 1'b1;
            w_seg[7*d +: 7] = v_seen ? seg7(r_work[4*d +: 4]) : 7'h7F;
        end
`else
        w_seg = '1;
        for (int d = 0; d < DIGITS; d++)
            w_seg[7*d +: 7] = seg7(r_work[4*d +: 4]);
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_last     <= '0;
            r_force    <= 1'b1;
            r_ovf_path <= 1'b0;
            r_shift    <= '0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_bcd      <= '0;
            r_hex      <= '1;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (out_port != r_last || r_force) begin
                        r_last     <= out_port;
                        r_force    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_ovf_path <= w_hi_nz;
                        if (w_hi_nz) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_shift <= out_port[DATA_W-1:0];
                            r_work  <= '0;
                            r_cnt   <= CNT_W'(DATA_W);
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_work  <= (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, r_shift[DATA_W-1]};
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1))
                        r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (r_ovf_path) begin
                        r_bcd <= '0;
                        r_hex <= {DIGITS{7'h3F}};
                        r_ovf <= 1'b1;
                    end else begin
                        r_bcd <= r_work;
                        r_hex <= w_seg;
                        r_ovf <= 1'b0;
                    end
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bcd       = r_bcd;
    assign hex_seg   = r_hex;
    assign busy      = r_busy;
    assign valid     = r_valid;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule
